// File: rtl/mult_seq_32bit_if.sv
// Handshake and result bundle for the sequential multiplier.
// The requester uses the master modport and the multiplier uses the slave modport.
interface mult_seq_32bit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_lo;
    logic [WIDTH-1:0] product_hi;

    modport master (
        output start, a, b,
        input  busy, done, product_lo, product_hi
    );

    modport slave (
        input  start, a, b,
        output busy, done, product_lo, product_hi
    );
endinterface

// File: rtl/mult_seq_32bit.sv
// Unsigned shift-add multiplier. Each clock retires one multiplier bit, and a start/done handshake controls it.
// Optional macro MULT_EARLY_EXIT_EN ends RUN as soon as no set multiplier bits remain.
module mult_seq_32bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_seq_32bit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    // acc is held outside RUN so the product stays visible until the next accepted start
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        finish   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
`ifdef MULT_EARLY_EXIT_EN
                finish   = (count_q == LAST_ITER) || (mplier_d == '0);
`else
                finish   = (count_q == LAST_ITER);
`endif
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.product_lo = acc_q[WIDTH-1:0];
    assign bus.product_hi = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mult_seq_32bit.sv
// Self-checking bench for mult_seq_32bit. A scoreboard queues the expected product and latency for each accepted start.
// Define MULT_EARLY_EXIT_EN for both the bench and the RTL to check the early-exit latency.
module tb_mult_seq_32bit;

    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;

    logic [2*WIDTH-1:0] expProdQ[$];
    int                 expLatQ[$];

    mult_seq_32bit_if #(.WIDTH(WIDTH)) busIf ();

    mult_seq_32bit #(
        .WIDTH (WIDTH),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [2*WIDTH-1:0] observed,
                               input logic [2*WIDTH-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference latency: a fixed WIDTH cycles, or with early exit the position of the top set bit of b (minimum 1)
    function automatic int modelLatency(input logic [WIDTH-1:0] bIn);
        int lat;
`ifdef MULT_EARLY_EXIT_EN
        lat = 1;
        for (int i = 0; i < WIDTH; i++) begin
            if (bIn[i]) lat = i + 1;
        end
`else
        lat = WIDTH;
`endif
        return lat;
    endfunction

    // Drive a start that is accepted at the next rising edge (E0), and record the expectation
    task automatic applyStimulus(input logic [WIDTH-1:0] aIn, input logic [WIDTH-1:0] bIn);
        @(negedge clk);
        busIf.start = 1'b1;
        busIf.a     = aIn;
        busIf.b     = bIn;
        expProdQ.push_back({{WIDTH{1'b0}}, aIn} * {{WIDTH{1'b0}}, bIn});
        expLatQ.push_back(modelLatency(bIn));
        @(posedge clk);
        #1;
        busIf.start = 1'b0;
    endtask

    // Wait for done and compare against the scoreboard head. The operation may be disturbed with a start at edge intrudeAt
    task automatic waitDone(input int intrudeAt);
        logic [2*WIDTH-1:0] expProd;
        logic [2*WIDTH-1:0] heldProd;
        int                 expLat;
        int                 k;
        bit                 seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk);
            k++;
            if (k == intrudeAt) begin
                #1;
                busIf.start = 1'b1;
                busIf.a     = 32'd1;
                busIf.b     = 32'd1;
            end else if (k == intrudeAt + 1) begin
                #1;
                busIf.start = 1'b0;
            end
            @(negedge clk);
            if (busIf.done) begin
                seen = 1'b1;
            end else begin
                checkOutput("busyDuringRun", {63'd0, busIf.busy}, 64'd1);
            end
        end
        if (!seen) begin
            checkOutput("doneTimeout", 64'd0, 64'd1);
        end
        if (expProdQ.size() == 0) begin
            checkOutput("scoreboardEmpty", 64'd0, 64'd1);
        end else begin
            expProd = expProdQ.pop_front();
            expLat  = expLatQ.pop_front();
            if (seen) begin
                checkOutput("latency", 64'(k), 64'(expLat));
                checkOutput("product", {busIf.product_hi, busIf.product_lo}, expProd);
                checkOutput("busyWithDone", {63'd0, busIf.busy}, 64'd0);
                heldProd = expProd;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("singleDone", {63'd0, busIf.done}, 64'd0);
                    checkOutput("productHeld", {busIf.product_hi, busIf.product_lo}, heldProd);
                end
            end
        end
    endtask

    initial begin
        checkCount  = 0;
        passCount   = 0;
        rst_n       = 1'b0;
        busIf.start = 1'b0;
        busIf.a     = '0;
        busIf.b     = '0;

        #3;
        checkOutput("resetBusy", {63'd0, busIf.busy}, 64'd0);
        checkOutput("resetDone", {63'd0, busIf.done}, 64'd0);
        checkOutput("resetProduct", {busIf.product_hi, busIf.product_lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic operation; then an asynchronous reset between edges must clear the held product at once
        applyStimulus(32'd3, 32'd5);
        waitDone(-1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstProduct", {busIf.product_hi, busIf.product_lo}, 64'd0);
        checkOutput("asyncRstBusy", {63'd0, busIf.busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(-1);

        // Second start at E5 must be ignored
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0);
        waitDone(5);

        for (int i = 0; i < 3; i++) begin
            applyStimulus($urandom, $urandom);
            waitDone(-1);
        end

        // Reset at E10 aborts the operation with no done pulse
        applyStimulus(32'h0001_0000, 32'h0001_0000);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", {63'd0, busIf.busy}, 64'd0);
        checkOutput("midRstDone", {63'd0, busIf.done}, 64'd0);
        checkOutput("midRstProduct", {busIf.product_hi, busIf.product_lo}, 64'd0);
        expProdQ.delete();
        expLatQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("noDoneAfterAbort", {63'd0, busIf.done}, 64'd0);
        end

        applyStimulus(32'd2, 32'd7);
        waitDone(-1);

        applyStimulus(32'd7, 32'd2);
        waitDone(-1);

        applyStimulus(32'hDEAD_BEEF, 32'd0);
        waitDone(-1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
